// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer: reset / enable-streaming handshake with timeout
// and bounded retry, then 3-byte movement packet framing and decode.
module ps2_mouse_init_ctrl #(
  parameter int TIMEOUT_CYC = 25_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              tx_idle,
  input  logic              tx_done_tick,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  output logic              wr_ps2,
  output logic [7:0]        cmd,
  output logic signed [8:0] xm,
  output logic signed [8:0] ym,
  output logic [2:0]        btn,
  output logic              m_done_tick,
  output logic              ready,
  output logic              err
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  localparam logic [7:0] CMD_RST = 8'hFF;
  localparam logic [7:0] CMD_EN  = 8'hF4;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam logic [7:0] RSP_BAT = 8'hAA;
  localparam logic [7:0] RSP_ID  = 8'h00;

  typedef enum logic [3:0] {
    SEND_RST,
    WAIT_RST_TX,
    WAIT_ACK1,
    WAIT_BAT,
    WAIT_ID,
    SEND_EN,
    WAIT_EN_TX,
    WAIT_ACK2,
    STREAM_B0,
    STREAM_B1,
    STREAM_B2,
    FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [RW-1:0]     retry_inc;
  logic              wr_q, wr_d;
  logic [7:0]        cmd_q, cmd_d;
  logic signed [8:0] xm_q, xm_d;
  logic signed [8:0] ym_q, ym_d;
  logic [2:0]        btn_q, btn_d;
  logic              mdone_q, mdone_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [7:0]        b0_q, b0_d;
  logic [7:0]        b1_q, b1_d;
  logic              timed_out;
  logic              fail_attempt;

  function automatic logic is_timed_state(input state_t s);
    case (s)
      WAIT_RST_TX, WAIT_ACK1, WAIT_BAT, WAIT_ID,
      WAIT_EN_TX, WAIT_ACK2, STREAM_B1, STREAM_B2: is_timed_state = 1'b1;
      default:                                     is_timed_state = 1'b0;
    endcase
  endfunction

  function automatic logic is_stream_state(input state_t s);
    is_stream_state = (s == STREAM_B0) || (s == STREAM_B1) || (s == STREAM_B2);
  endfunction

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    retry_inc    = retry_q + RW'(1);
    wr_d         = 1'b0;
    cmd_d        = cmd_q;
    xm_d         = xm_q;
    ym_d         = ym_q;
    btn_d        = btn_q;
    mdone_d      = 1'b0;
    b0_d         = b0_q;
    b1_d         = b1_q;
    fail_attempt = 1'b0;
    timed_out    = (timer_q == TIMER_LAST);

    if (start) begin
      state_d = SEND_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        SEND_RST: begin
          if (tx_idle) begin
            wr_d    = 1'b1;
            cmd_d   = CMD_RST;
            state_d = WAIT_RST_TX;
          end
        end
        WAIT_RST_TX: begin
          if (tx_done_tick)   state_d      = WAIT_ACK1;
          else if (timed_out) fail_attempt = 1'b1;
        end
        WAIT_ACK1: begin
          if (rx_done_tick) begin
            if (rx_data == RSP_ACK) state_d      = WAIT_BAT;
            else                    fail_attempt = 1'b1;
          end else if (timed_out) begin
            fail_attempt = 1'b1;
          end
        end
        WAIT_BAT: begin
          if (rx_done_tick) begin
            if (rx_data == RSP_BAT) state_d      = WAIT_ID;
            else                    fail_attempt = 1'b1;
          end else if (timed_out) begin
            fail_attempt = 1'b1;
          end
        end
        WAIT_ID: begin
          if (rx_done_tick) begin
            if (rx_data == RSP_ID) state_d      = SEND_EN;
            else                   fail_attempt = 1'b1;
          end else if (timed_out) begin
            fail_attempt = 1'b1;
          end
        end
        SEND_EN: begin
          if (tx_idle) begin
            wr_d    = 1'b1;
            cmd_d   = CMD_EN;
            state_d = WAIT_EN_TX;
          end
        end
        WAIT_EN_TX: begin
          if (tx_done_tick)   state_d      = WAIT_ACK2;
          else if (timed_out) fail_attempt = 1'b1;
        end
        WAIT_ACK2: begin
          if (rx_done_tick) begin
            if (rx_data == RSP_ACK) begin
              state_d = STREAM_B0;
              retry_d = '0;
            end else begin
              fail_attempt = 1'b1;
            end
          end else if (timed_out) begin
            fail_attempt = 1'b1;
          end
        end
        // bit 3 of the first packet byte is always 1; anything else is a resync drop
        STREAM_B0: begin
          if (rx_done_tick && rx_data[3]) begin
            b0_d    = rx_data;
            state_d = STREAM_B1;
          end
        end
        STREAM_B1: begin
          if (rx_done_tick) begin
            b1_d    = rx_data;
            state_d = STREAM_B2;
          end else if (timed_out) begin
            state_d = STREAM_B0;
          end
        end
        STREAM_B2: begin
          if (rx_done_tick) begin
            xm_d    = $signed({b0_q[4], b1_q});
            ym_d    = $signed({b0_q[5], rx_data});
            btn_d   = b0_q[2:0];
            mdone_d = 1'b1;
            state_d = STREAM_B0;
          end else if (timed_out) begin
            state_d = STREAM_B0;
          end
        end
        FAIL:    state_d = FAIL;
        default: state_d = SEND_RST;
      endcase

      if (fail_attempt) begin
        retry_d = retry_inc;
        state_d = (retry_inc < RETRY_MAX) ? SEND_RST : FAIL;
      end
    end

    ready_d = is_stream_state(state_d);
    err_d   = (state_d == FAIL);

    if (start || (state_d != state_q) || !is_timed_state(state_q)) timer_d = '0;
    else                                                           timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEND_RST;
      timer_q <= '0;
      retry_q <= '0;
      wr_q    <= 1'b0;
      cmd_q   <= 8'h00;
      xm_q    <= '0;
      ym_q    <= '0;
      btn_q   <= '0;
      mdone_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      wr_q    <= wr_d;
      cmd_q   <= cmd_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      btn_q   <= btn_d;
      mdone_q <= mdone_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Partial-packet bytes need no reset: the FSM always rewrites them before use.
  always_ff @(posedge clk) begin
    b0_q <= b0_d;
    b1_q <= b1_d;
  end

  assign wr_ps2      = wr_q;
  assign cmd         = cmd_q;
  assign xm          = xm_q;
  assign ym          = ym_q;
  assign btn         = btn_q;
  assign m_done_tick = mdone_q;
  assign ready       = ready_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed bench for ps2_mouse_init_ctrl: init handshake, packet decode table,
// resync, retry/FAIL, timeouts, async reset mid-packet and start priority.
`timescale 1ns/1ps
module tb_ps2_mouse_init_ctrl;

  logic       clk          = 1'b0;
  logic       reset        = 1'b0;
  logic       start        = 1'b0;
  logic       tx_idle      = 1'b1;
  logic       tx_done_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data      = 8'h00;
  logic       wr_ps2;
  logic [7:0] cmd;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btn;
  logic       m_done_tick;
  logic       ready;
  logic       err;

  int checks    = 0;
  int failures  = 0;
  int mdone_cnt = 0;
  int wr_cnt    = 0;
  int n;
  int c0;
  int w0;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [8:0] exp_xm;
    logic [8:0] exp_ym;
    logic [2:0] exp_btn;
  } pkt_vec_t;

  pkt_vec_t vecs [6];

  always #5 clk = ~clk;

  ps2_mouse_init_ctrl #(
    .TIMEOUT_CYC(100),
    .MAX_RETRY  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .wr_ps2      (wr_ps2),
    .cmd         (cmd),
    .xm          (xm),
    .ym          (ym),
    .btn         (btn),
    .m_done_tick (m_done_tick),
    .ready       (ready),
    .err         (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_done_tick) mdone_cnt++;
    if (wr_ps2)      wr_cnt++;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
  endtask

  task automatic pulse_tx_done();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  task automatic wait_wr(input string name, input logic [7:0] exp_cmd, input int maxc,
                         output int cyc);
    cyc = 0;
    while (!wr_ps2 && cyc < maxc) begin
      tick();
      cyc++;
    end
    check({name, "_wr"}, {31'd0, wr_ps2}, 32'd1);
    check({name, "_cmd"}, {24'd0, cmd}, {24'd0, exp_cmd});
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_rx(b0);
    tick();
    send_rx(b1);
    tick();
    send_rx(b2);
  endtask

  // Starts with the 0xFF strobe visible, ends one cycle after the ACK2 byte.
  task automatic finish_init(input string name);
    int k;
    tick();
    check({name, "_wr_one_cycle"}, {31'd0, wr_ps2}, 32'd0);
    pulse_tx_done();
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    wait_wr({name, "_en"}, 8'hF4, 10, k);
    pulse_tx_done();
    check({name, "_ready_before_ack2"}, {31'd0, ready}, 32'd0);
    send_rx(8'hFA);
    check({name, "_ready"}, {31'd0, ready}, 32'd1);
    check({name, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h18, 8'hFE, 8'h05, 9'h1FE, 9'h005, 3'b000};
    vecs[1] = '{8'h29, 8'h10, 8'hF0, 9'h010, 9'h1F0, 3'b001};
    vecs[2] = '{8'h08, 8'h01, 8'h02, 9'h001, 9'h002, 3'b000};
    vecs[3] = '{8'h3F, 8'hFF, 8'hFF, 9'h1FF, 9'h1FF, 3'b111};
    vecs[4] = '{8'hCF, 8'h80, 8'h7F, 9'h080, 9'h07F, 3'b111};
    vecs[5] = '{8'h1C, 8'h00, 8'h00, 9'h100, 9'h000, 3'b100};

    repeat (3) tick();
    check("rst_wr",    {31'd0, wr_ps2},      32'd0);
    check("rst_cmd",   {24'd0, cmd},         32'd0);
    check("rst_xm",    {23'd0, xm},          32'd0);
    check("rst_ym",    {23'd0, ym},          32'd0);
    check("rst_btn",   {29'd0, btn},         32'd0);
    check("rst_mdone", {31'd0, m_done_tick}, 32'd0);
    check("rst_ready", {31'd0, ready},       32'd0);
    check("rst_err",   {31'd0, err},         32'd0);

    reset = 1'b1;
    wait_wr("init_rst", 8'hFF, 10, n);
    check("init_wr_first_edge", n, 1);
    finish_init("init");

    for (int i = 0; i < 6; i++) begin
      c0 = mdone_cnt;
      send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      check($sformatf("pkt%0d_done", i), {31'd0, m_done_tick}, 32'd1);
      check($sformatf("pkt%0d_xm", i),   {23'd0, xm},  {23'd0, vecs[i].exp_xm});
      check($sformatf("pkt%0d_ym", i),   {23'd0, ym},  {23'd0, vecs[i].exp_ym});
      check($sformatf("pkt%0d_btn", i),  {29'd0, btn}, {29'd0, vecs[i].exp_btn});
      tick();
      check($sformatf("pkt%0d_done_once", i), mdone_cnt - c0, 1);
      check($sformatf("pkt%0d_xm_hold", i), {23'd0, xm}, {23'd0, vecs[i].exp_xm});
    end

    // Resync: a first byte with bit3=0 is dropped.
    c0 = mdone_cnt;
    send_rx(8'h00);
    tick();
    send_pkt(8'h08, 8'h01, 8'h02);
    tick();
    check("resync_count", mdone_cnt - c0, 1);
    check("resync_xm", {23'd0, xm}, 32'h001);
    check("resync_ym", {23'd0, ym}, 32'h002);

    // Timeout in STREAM_B1 falls back to B0 silently.
    c0 = mdone_cnt;
    send_rx(8'h08);
    repeat (120) tick();
    check("b1_timeout_no_done", mdone_cnt - c0, 0);
    check("b1_timeout_ready", {31'd0, ready}, 32'd1);
    send_pkt(8'h0D, 8'h03, 8'h04);
    check("b1_timeout_resume_done", {31'd0, m_done_tick}, 32'd1);
    check("b1_timeout_resume_xm", {23'd0, xm}, 32'h003);
    check("b1_timeout_resume_ym", {23'd0, ym}, 32'h004);
    check("b1_timeout_resume_btn", {29'd0, btn}, 32'h5);
    tick();

    // Asynchronous reset after B0 and B1.
    send_rx(8'h1D);
    tick();
    send_rx(8'h22);
    c0 = mdone_cnt;
    reset = 1'b0;
    #1;
    check("midrst_wr",    {31'd0, wr_ps2},      32'd0);
    check("midrst_cmd",   {24'd0, cmd},         32'd0);
    check("midrst_xm",    {23'd0, xm},          32'd0);
    check("midrst_ym",    {23'd0, ym},          32'd0);
    check("midrst_btn",   {29'd0, btn},         32'd0);
    check("midrst_mdone", {31'd0, m_done_tick}, 32'd0);
    check("midrst_ready", {31'd0, ready},       32'd0);
    check("midrst_err",   {31'd0, err},         32'd0);
    tick();
    tick();
    reset = 1'b1;
    wait_wr("midrst_reissue", 8'hFF, 10, n);
    w0 = wr_cnt;
    send_rx(8'h33);

    // Three bad acks: two reissues then FAIL.
    pulse_tx_done();
    send_rx(8'hFE);
    wait_wr("retry1", 8'hFF, 10, n);
    pulse_tx_done();
    send_rx(8'hFE);
    wait_wr("retry2", 8'hFF, 10, n);
    pulse_tx_done();
    check("retry_err_before_fail", {31'd0, err}, 32'd0);
    send_rx(8'hFE);
    check("fail_err", {31'd0, err}, 32'd1);
    check("fail_ready", {31'd0, ready}, 32'd0);
    check("fail_reissue_count", wr_cnt - w0, 2);
    w0 = wr_cnt;
    repeat (50) tick();
    send_rx(8'hFA);
    tick();
    check("fail_no_wr", wr_cnt - w0, 0);
    check("fail_err_hold", {31'd0, err}, 32'd1);
    check("midrst_no_done", mdone_cnt - c0, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_err", {31'd0, err}, 32'd0);
    wait_wr("start", 8'hFF, 5, n);

    // No response after the command: reissue after about TIMEOUT_CYC cycles.
    pulse_tx_done();
    wait_wr("timeout", 8'hFF, 200, n);
    check("timeout_window", {31'd0, (n >= 99 && n <= 103)}, 32'd1);
    finish_init("reinit");

    // start wins over a simultaneous B2 byte.
    send_rx(8'h08);
    tick();
    send_rx(8'h01);
    tick();
    c0           = mdone_cnt;
    start        = 1'b1;
    rx_data      = 8'h02;
    rx_done_tick = 1'b1;
    tick();
    start        = 1'b0;
    rx_done_tick = 1'b0;
    check("start_prio_ready", {31'd0, ready}, 32'd0);
    check("start_prio_no_done", mdone_cnt - c0, 0);
    wait_wr("start_prio", 8'hFF, 5, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
